wb_stage: RTL and testbench

Registered, parametrised writeback stage for the RISC-V core.
- Selects result source: load data, ALU result, or PC+4.
- Performs load byte/half/word lane extraction with sign/zero extension.
- Carries destination register and write-enable through a 2-entry skid buffer with valid/ready handshake.
- Sits between the memory-access stage and the register file write port.

---
 rtl/wb_pkg.sv | 35 +++
 rtl/wb_load_align.sv | 48 ++++
 rtl/wb_stage.sv | 161 ++++++++++++++++
 tb/tb_wb_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and encodings for the writeback stage.
package wb_pkg;

  // Storage widths of a buffered entry (largest supported XLEN / RA_W).
  localparam int unsigned WB_DATA_MAX = 64;
  localparam int unsigned WB_RD_MAX   = 8;

  // Result source select.
  typedef enum logic [1:0] {
    WB_MEM = 2'b00,
    WB_ALU = 2'b01,
    WB_PC4 = 2'b10,
    WB_RSV = 2'b11
  } wbsel_e;

  // Load funct3 codes.
  typedef enum logic [2:0] {
    F3_LB  = 3'b000,
    F3_LH  = 3'b001,
    F3_LW  = 3'b010,
    F3_LD  = 3'b011,
    F3_LBU = 3'b100,
    F3_LHU = 3'b101,
    F3_LWU = 3'b110
  } load_f3_e;

  // One buffered writeback entry; narrower configurations use the low bits.
  typedef struct packed {
    logic [WB_RD_MAX-1:0]   rd;
    logic                   we;
    logic [WB_DATA_MAX-1:0] data;
    logic                   err;
  } wb_entry_t;

endpackage

// File: rtl/wb_load_align.sv
// Load lane extraction with sign/zero extension (purely combinational).
module wb_load_align
  import wb_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  localparam int unsigned ALO_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  mem_i,
  input  logic [2:0]       funct3_i,
  input  logic [ALO_W-1:0] lane_i,
  output logic [XLEN-1:0]  data_c,
  output logic             misalign_c
);

  logic [ALO_W-1:0] lane_h;
  logic [ALO_W-1:0] lane_w;
  logic [XLEN-1:0]  byte_sh;
  logic [XLEN-1:0]  half_sh;
  logic [XLEN-1:0]  word_sh;

  // Align the addressed byte/half/word to bit 0, then extend by funct3.
  always_comb begin
    lane_h     = lane_i & ~ALO_W'(1);
    lane_w     = lane_i & ~ALO_W'(3);
    byte_sh    = mem_i >> {lane_i, 3'b000};
    half_sh    = mem_i >> {lane_h, 3'b000};
    word_sh    = mem_i >> {lane_w, 3'b000};
    data_c     = mem_i;
    misalign_c = 1'b0;
    case (funct3_i)
      F3_LB:  data_c = XLEN'($signed(byte_sh[7:0]));
      F3_LBU: data_c = XLEN'(byte_sh[7:0]);
      F3_LH: begin
        data_c     = XLEN'($signed(half_sh[15:0]));
        misalign_c = lane_i[0];
      end
      F3_LHU: begin
        data_c     = XLEN'(half_sh[15:0]);
        misalign_c = lane_i[0];
      end
      F3_LW:  data_c = XLEN'($signed(word_sh[31:0]));
      // LWU only differs from LW on RV64.
      F3_LWU: data_c = (XLEN == 64) ? XLEN'(word_sh[31:0]) : XLEN'($signed(word_sh[31:0]));
      default: data_c = mem_i;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: result select, load alignment and a 2-entry skid buffer.
// Optional retire counter port enabled by defining WB_RETIRE_CNT_EN.
module wb_stage
  import wb_pkg::*;
#(
  parameter  int unsigned XLEN  = 32,
  parameter  int unsigned RA_W  = 5,
  localparam int unsigned ALO_W = $clog2(XLEN / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_wbsel,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_alu,
  input  logic [XLEN-1:0]  in_mem,
  input  logic [2:0]       in_funct3,
  input  logic [ALO_W-1:0] in_addr_lo,
  input  logic [RA_W-1:0]  in_rd,
  input  logic             in_rf_we,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [RA_W-1:0]  out_rd,
  output logic             out_we,
  output logic [XLEN-1:0]  out_data,
  output logic             out_err
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [63:0]      retire_cnt
`endif
);

  logic [XLEN-1:0] ld_data_c;
  logic            ld_misalign_c;
  logic [XLEN-1:0] res_c;
  logic            err_c;
  logic            we_c;
  wb_entry_t       in_entry_c;

  wb_entry_t main_q, main_d;
  wb_entry_t skid_q, skid_d;
  logic      main_v_q, main_v_d;
  logic      skid_v_q, skid_v_d;
  logic      in_ready_q, in_ready_d;
  logic      push_c;
  logic      pop_c;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .mem_i      (in_mem),
    .funct3_i   (in_funct3),
    .lane_i     (in_addr_lo),
    .data_c     (ld_data_c),
    .misalign_c (ld_misalign_c)
  );

  // Result select and write-enable qualification for the incoming entry.
  always_comb begin
    res_c = '0;
    err_c = 1'b0;
    case (in_wbsel)
      WB_MEM: begin
        res_c = ld_data_c;
        err_c = ld_misalign_c;
      end
      WB_ALU: res_c = in_alu;
      WB_PC4: res_c = in_pc + XLEN'(4);
      default: begin
        res_c = '0;
        err_c = 1'b1;
      end
    endcase
    we_c            = in_rf_we && (in_rd != '0) && (in_wbsel != WB_RSV);
    in_entry_c.rd   = WB_RD_MAX'(in_rd);
    in_entry_c.we   = we_c;
    in_entry_c.data = WB_DATA_MAX'(res_c);
    in_entry_c.err  = err_c;
  end

  // Skid buffer next state: main feeds the outputs, skid catches one stalled push.
  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    push_c   = in_valid && in_ready_q;
    pop_c    = main_v_q && out_ready;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!main_v_q || pop_c) begin
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else if (push_c) begin
        main_d   = in_entry_c;
        main_v_d = 1'b1;
      end else begin
        main_v_d = 1'b0;
      end
    end else if (push_c) begin
      skid_d   = in_entry_c;
      skid_v_d = 1'b1;
    end
    // Keep the write enable low whenever main holds nothing.
    if (!main_v_d) begin
      main_d.we = 1'b0;
    end
    in_ready_d = !skid_v_d;
  end

  // Buffer state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_v_q   <= 1'b0;
      skid_v_q   <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_v_q   <= main_v_d;
      skid_v_q   <= skid_v_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_rd    = RA_W'(main_q.rd);
  assign out_we    = main_q.we;
  assign out_data  = XLEN'(main_q.data);
  assign out_err   = main_q.err;

`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt_q, retire_cnt_d;

  // Saturating count of delivered entries; only reset clears it.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    if (pop_c && (retire_cnt_q != '1)) begin
      retire_cnt_d = retire_cnt_q + 64'd1;
    end
  end

  // Retire counter register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      retire_cnt_q <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage (XLEN=32).
// Retire counter checks run only when WB_RETIRE_CNT_EN is defined.
module tb_wb_stage;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_wbsel;
  logic [31:0] in_pc;
  logic [31:0] in_alu;
  logic [31:0] in_mem;
  logic [2:0]  in_funct3;
  logic [1:0]  in_addr_lo;
  logic [4:0]  in_rd;
  logic        in_rf_we;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_rd;
  logic        out_we;
  logic [31:0] out_data;
  logic        out_err;
`ifdef WB_RETIRE_CNT_EN
  logic [63:0] retire_cnt;
`endif

  int n_checks;
  int n_fail;

  wb_stage #(.XLEN(32), .RA_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_wbsel   (in_wbsel),
    .in_pc      (in_pc),
    .in_alu     (in_alu),
    .in_mem     (in_mem),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_rd      (in_rd),
    .in_rf_we   (in_rf_we),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_rd     (out_rd),
    .out_we     (out_we),
    .out_data   (out_data),
    .out_err    (out_err)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [2:0]  f3;
    logic [1:0]  lane;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp_data;
    logic        exp_we;
    logic        exp_err;
  } vec_t;

  vec_t vecs[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive_alu(input logic [31:0] val, input logic [4:0] rd);
    in_valid   = 1'b1;
    in_wbsel   = 2'b01;
    in_alu     = val;
    in_rd      = rd;
    in_rf_we   = 1'b1;
    in_funct3  = 3'b000;
    in_addr_lo = 2'd0;
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst        = 1'b0;
    flush      = 1'b0;
    in_valid   = 1'b0;
    in_wbsel   = 2'b00;
    in_pc      = '0;
    in_alu     = '0;
    in_mem     = '0;
    in_funct3  = '0;
    in_addr_lo = '0;
    in_rd      = '0;
    in_rf_we   = 1'b0;
    out_ready  = 1'b1;

    //            sel    pc            alu           mem           f3      lane  rd  we  exp_data      we    err
    vecs[0]  = '{2'b01, 32'h0,        32'h12345678, 32'h0,        3'b000, 2'd0, 5, 1, 32'h12345678, 1'b1, 1'b0};
    vecs[1]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b000, 2'd3, 6, 1, 32'hFFFFFF80, 1'b1, 1'b0};
    vecs[2]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b100, 2'd3, 6, 1, 32'h00000080, 1'b1, 1'b0};
    vecs[3]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b001, 2'd2, 7, 1, 32'hFFFF80FF, 1'b1, 1'b0};
    vecs[4]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b001, 2'd1, 7, 1, 32'h00007F01, 1'b1, 1'b1};
    vecs[5]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b101, 2'd2, 8, 1, 32'h000080FF, 1'b1, 1'b0};
    vecs[6]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b000, 2'd0, 8, 1, 32'h00000001, 1'b1, 1'b0};
    vecs[7]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b000, 2'd1, 9, 1, 32'h0000007F, 1'b1, 1'b0};
    vecs[8]  = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b010, 2'd0, 9, 1, 32'h80FF7F01, 1'b1, 1'b0};
    vecs[9]  = '{2'b10, 32'hFFFFFFFC, 32'h0,        32'h0,        3'b000, 2'd0, 0, 1, 32'h00000000, 1'b0, 1'b0};
    vecs[10] = '{2'b10, 32'h00000100, 32'h0,        32'h0,        3'b000, 2'd0, 3, 1, 32'h00000104, 1'b1, 1'b0};
    vecs[11] = '{2'b11, 32'h0,        32'h55,       32'h0,        3'b000, 2'd0, 4, 1, 32'h00000000, 1'b0, 1'b1};
    vecs[12] = '{2'b01, 32'h0,        32'hDEADBEEF, 32'h0,        3'b000, 2'd0, 0, 1, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[13] = '{2'b00, 32'h0,        32'h0,        32'hCAFEF00D, 3'b111, 2'd3, 10, 1, 32'hCAFEF00D, 1'b1, 1'b0};
    vecs[14] = '{2'b00, 32'h0,        32'h0,        32'h80FF7F01, 3'b100, 2'd2, 11, 1, 32'h000000FF, 1'b1, 1'b0};
    vecs[15] = '{2'b01, 32'h0,        32'h00000042, 32'h0,        3'b000, 2'd0, 7, 0, 32'h00000042, 1'b0, 1'b0};

    // Reset state
    repeat (2) step();
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_we",    64'(out_we),    64'd0);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_out_rd",    64'(out_rd),    64'd0);
    chk("rst_out_err",   64'(out_err),   64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    rst = 1'b1;
    step();

    // Streaming table vectors, one per cycle, out_ready held high
    for (int i = 0; i < 16; i++) begin
      in_valid   = 1'b1;
      in_wbsel   = vecs[i].sel;
      in_pc      = vecs[i].pc;
      in_alu     = vecs[i].alu;
      in_mem     = vecs[i].mem;
      in_funct3  = vecs[i].f3;
      in_addr_lo = vecs[i].lane;
      in_rd      = vecs[i].rd;
      in_rf_we   = vecs[i].we;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'd1);
      chk($sformatf("vec%0d_data", i),  64'(out_data),  64'(vecs[i].exp_data));
      chk($sformatf("vec%0d_rd", i),    64'(out_rd),    64'(vecs[i].rd));
      chk($sformatf("vec%0d_we", i),    64'(out_we),    64'(vecs[i].exp_we));
      chk($sformatf("vec%0d_err", i),   64'(out_err),   64'(vecs[i].exp_err));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 64'(out_valid), 64'd0);
    chk("drain_we",    64'(out_we),    64'd0);

    // Backpressure: A and B accepted, C held off, then delivered in order
    out_ready = 1'b0;
    drive_alu(32'hA, 5'd1);
    step();
    chk("bp_a_valid", 64'(out_valid), 64'd1);
    chk("bp_a_data",  64'(out_data),  64'hA);
    chk("bp_a_ready", 64'(in_ready),  64'd1);
    drive_alu(32'hB, 5'd2);
    step();
    chk("bp_b_ready", 64'(in_ready),  64'd0);
    chk("bp_hold_a",  64'(out_data),  64'hA);
    drive_alu(32'hC, 5'd3);
    step();
    chk("bp_c_ready", 64'(in_ready),  64'd0);
    chk("bp_hold_a2", 64'(out_data),  64'hA);
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", 64'(out_valid), 64'd1);
    chk("bp_b_data",  64'(out_data),  64'hB);
    chk("bp_b_rd",    64'(out_rd),    64'd2);
    chk("bp_ready_up", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    chk("bp_c_valid", 64'(out_valid), 64'd1);
    chk("bp_c_data",  64'(out_data),  64'hC);
    chk("bp_c_rd",    64'(out_rd),    64'd3);
    step();
    chk("bp_empty",   64'(out_valid), 64'd0);

    // Flush with both entries full and a push in the same cycle
    out_ready = 1'b0;
    drive_alu(32'hD, 5'd4);
    step();
    drive_alu(32'hE, 5'd5);
    step();
    chk("fl_full_ready", 64'(in_ready), 64'd0);
    drive_alu(32'hF, 5'd6);
    flush = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("fl_nodeliver%0d", k), 64'(out_valid), 64'd0);
    end

    // Reset in the middle of a stalled handshake
    out_ready = 1'b0;
    drive_alu(32'h77, 5'd7);
    step();
    in_valid = 1'b0;
    chk("mr_loaded", 64'(out_valid), 64'd1);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("mr_valid", 64'(out_valid), 64'd0);
    chk("mr_ready", 64'(in_ready),  64'd1);
    out_ready = 1'b1;
    step();
    chk("mr_nodeliver", 64'(out_valid), 64'd0);

`ifdef WB_RETIRE_CNT_EN
    // Retire counter: 10 handshakes, three with rd=0
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rc_clear", retire_cnt, 64'd0);
    for (int j = 0; j < 10; j++) begin
      drive_alu(32'(j), (j < 3) ? 5'd0 : 5'(j));
      step();
    end
    in_valid = 1'b0;
    step();
    chk("rc_count10", retire_cnt, 64'd10);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("rc_flush_keeps", retire_cnt, 64'd10);
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("rc_reset", retire_cnt, 64'd0);
    chk("rc_reset_valid", 64'(out_valid), 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
